dct8x8_fwd: RTL

- Forward 8x8 2-D DCT. It is the encode-side counterpart of the team's IDCT block.
- Samples are loaded into a 64-entry block by index and computed sequentially: a row pass, then a column pass, on one time-shared MAC. Coefficients are then read out by index.
- It sits ahead of quantisation and feeds coefficients in the same row-major 0..63 ordering the IDCT consumes.

---
 rtl/dct8x8_fwd.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dct8x8_fwd.sv
// Forward 8x8 2-D DCT: row pass then column pass on one shared MAC.
// Samples in and coefficients out are indexed row-major 0..63.
module dct8x8_fwd #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 12,
  parameter int MID_W = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              Mode,
  input  logic [5:0]              Array_Value,
  input  logic signed [IN_W-1:0]  Value_in,
  output logic signed [OUT_W-1:0] Value_out,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_e;

  localparam logic signed [8:0] TBL [64] = '{
    9'sd91,  9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,
    9'sd126, 9'sd106,  9'sd71,   9'sd25,  -9'sd25,  -9'sd71,  -9'sd106, -9'sd126,
    9'sd118, 9'sd49,  -9'sd49,  -9'sd118, -9'sd118, -9'sd49,   9'sd49,   9'sd118,
    9'sd106, -9'sd25, -9'sd126, -9'sd71,   9'sd71,   9'sd126,  9'sd25,  -9'sd106,
    9'sd91,  -9'sd91, -9'sd91,   9'sd91,   9'sd91,  -9'sd91,  -9'sd91,   9'sd91,
    9'sd71,  -9'sd126, 9'sd25,   9'sd106, -9'sd106, -9'sd25,   9'sd126, -9'sd71,
    9'sd49,  -9'sd118, 9'sd118, -9'sd49,  -9'sd49,   9'sd118, -9'sd118,  9'sd49,
    9'sd25,  -9'sd71,  9'sd106, -9'sd126,  9'sd126, -9'sd106,  9'sd71,  -9'sd25
  };

  localparam logic signed [25:0] OMAX = 26'sd1 <<< (OUT_W - 1);
  localparam logic signed [25:0] SMAX = OMAX - 26'sd1;
  localparam logic signed [25:0] SMIN = -OMAX;

  state_e                   state_q, state_d;
  logic [5:0]               idx_q, idx_d;
  logic [3:0]               step_q, step_d;
  logic signed [25:0]       acc_q, acc_d;
  logic signed [IN_W-1:0]   x_q [64];
  logic signed [IN_W-1:0]   x_d [64];
  logic signed [MID_W-1:0]  y_q [64];
  logic signed [MID_W-1:0]  y_d [64];
  logic signed [OUT_W-1:0]  f_q [64];
  logic signed [OUT_W-1:0]  f_d [64];
  logic signed [OUT_W-1:0]  vout_q, vout_d;

  logic               in_row;
  logic [2:0]         k_sel;
  logic [2:0]         s;
  logic signed [25:0] opnd;
  logic signed [25:0] coef;
  logic signed [25:0] prod;
  logic signed [25:0] rnd;
  logic signed [OUT_W-1:0] sat;

  assign busy      = (state_q == ROW) || (state_q == COL);
  assign done      = (state_q == DONE);
  assign Value_out = vout_q;

  // Row pass walks outputs as r*8+k, column pass as k*8+c.
  always_comb begin
    in_row = (state_q == ROW);
    s      = step_q[2:0];
    k_sel  = in_row ? idx_q[2:0] : idx_q[5:3];
    coef   = 26'(TBL[{k_sel, s}]);
    opnd   = in_row ? 26'(x_q[{idx_q[5:3], s}])
                    : 26'(y_q[{s, idx_q[2:0]}]);
    prod   = opnd * coef;
    rnd    = (acc_q + 26'sd128) >>> 8;
    if (rnd > SMAX)      sat = SMAX[OUT_W-1:0];
    else if (rnd < SMIN) sat = SMIN[OUT_W-1:0];
    else                 sat = rnd[OUT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    f_d     = f_q;
    vout_d  = vout_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Mode == 2'd1) x_d[Array_Value] = Value_in;
        if (Mode == 2'd2) begin
          state_d = ROW;
          idx_d   = '0;
          step_d  = '0;
        end
      end
      ROW, COL: begin
        if (step_q == 4'd8) begin
          if (in_row) y_d[idx_q] = rnd[MID_W-1:0];
          else        f_d[idx_q] = sat;
          step_d = '0;
          idx_d  = idx_q + 6'd1;
          if (idx_q == 6'd63) state_d = in_row ? COL : DONE;
        end else begin
          acc_d  = (step_q == 4'd0) ? prod : acc_q + prod;
          step_d = step_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (Mode == 2'd3 && !busy) vout_d = f_q[Array_Value];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      vout_q  <= '0;
      x_q     <= '{default: '0};
      y_q     <= '{default: '0};
      f_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      vout_q  <= vout_d;
      x_q     <= x_d;
      y_q     <= y_d;
      f_q     <= f_d;
    end
  end

endmodule
